// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with step increment, absolute loads and a
// circular return-address stack for call/return pairs.
`default_nettype none

module pc_sequencer #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0,
    parameter logic [WIDTH-1:0]   STEP      = WIDTH'(1),
    parameter int                 RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           en,
    input  logic                           ld,
    input  logic                           call,
    input  logic                           ret,
    input  logic [WIDTH-1:0]               ld_addr,
    output logic [WIDTH-1:0]               pc,
    output logic [WIDTH-1:0]               pc_next,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           ovf_err,
    output logic                           unf_err
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_INC,
        OP_LOAD,
        OP_CALL
    } op_t;

    // Registered state
    logic [WIDTH-1:0] pc_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             ovf_reg;
    logic             unf_reg;

    // Next-state values
    logic [PW-1:0]    wr_ptr_next;
    logic [CW-1:0]    count_next;
    logic             ovf_next;
    logic             unf_next;
    logic             push;

    // Return-address storage; contents are don't-care after reset
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic [PW-1:0]    top_ptr;
    logic [PW-1:0]    wr_ptr_inc;
    logic [WIDTH-1:0] top_addr;
    logic             stack_empty;
    logic             stack_full;
    op_t              op;

    assign pc_inc      = pc_reg + STEP;
    assign stack_empty = (count_reg == '0);
    assign stack_full  = (count_reg == CNT_FULL);

    // wr_ptr_reg points at the slot the next push writes; top is one behind it
    assign top_ptr    = (wr_ptr_reg == '0) ? PTR_LAST : wr_ptr_reg - PW'(1);
    assign wr_ptr_inc = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PW'(1);
    assign top_addr   = ras_mem[top_ptr];

    // Decode of the non-return actions; ret is handled first below
    always_comb begin
        op = OP_HOLD;
        if (en) begin
            if (call) begin
                op = OP_CALL;
            end else if (ld) begin
                op = OP_LOAD;
            end else begin
                op = OP_INC;
            end
        end
    end

    always_comb begin
        pc_next     = pc_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        ovf_next    = ovf_reg;
        unf_next    = unf_reg;
        push        = 1'b0;

        if (en && ret) begin
            if (!stack_empty) begin
                pc_next     = top_addr;
                wr_ptr_next = top_ptr;
                count_next  = count_reg - CW'(1);
            end else begin
                unf_next = 1'b1;
                pc_next  = pc_inc;
            end
        end else begin
            case (op)
                OP_CALL: begin
                    push        = 1'b1;
                    pc_next     = ld_addr;
                    wr_ptr_next = wr_ptr_inc;
                    // A full stack overwrites its oldest entry and keeps the count
                    if (stack_full) begin
                        ovf_next = 1'b1;
                    end else begin
                        count_next = count_reg + CW'(1);
                    end
                end
                OP_LOAD: pc_next = ld_addr;
                OP_INC:  pc_next = pc_inc;
                default: pc_next = pc_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_reg     <= RESET_VEC;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
        end else begin
            pc_reg     <= pc_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
            unf_reg    <= unf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[wr_ptr_reg] <= pc_inc;
        end
    end

    assign pc        = pc_reg;
    assign ras_count = count_reg;
    assign ras_empty = stack_empty;
    assign ras_full  = stack_full;
    assign ovf_err   = ovf_reg;
    assign unf_err   = unf_reg;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the processor's fetch stage, successor to the fixed 32-bit counter. It holds the current fetch address and advances it by a configurable step each enabled cycle. It also supports absolute loads for branches and jumps, and has a small hardware return-address stack (RAS) so that call/return pairs restore the address after the call without a register-file round trip. It feeds instruction-memory addressing and the branch/jump logic.

## Interface
Parameters:
- WIDTH, 32, address width in bits
- RESET_VEC, 0, value of pc after reset
- STEP, 1, increment applied per advance; WIDTH-bit, added modulo 2^WIDTH
- RAS_DEPTH, 4, return-address stack entries, ≥2

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- clr  input  1  reset, asynchronous, active-high
- en  input  1  advance enable; 0 = stall, no state changes
- ld  input  1  load pc from ld_addr (branch or jump)
- call  input  1  push pc+STEP onto RAS, load pc from ld_addr
- ret  input  1  pop RAS top into pc
- ld_addr  input  WIDTH  target for ld/call
- pc  output  WIDTH  current fetch address (registered)
- pc_next  output  WIDTH  value pc takes at next edge given current inputs (combinational)
- ras_count  output  $clog2(RAS_DEPTH+1)  valid entries
- ras_empty  output  1  ras_count==0
- ras_full  output  1  ras_count==RAS_DEPTH
- ovf_err  output  1  sticky, set by a call while full
- unf_err  output  1  sticky, set by a ret while empty

## Operation
- Reset (clr=1): pc=RESET_VEC, ras_count=0, stack pointer=0, ovf_err=unf_err=0, so ras_empty=1 and ras_full=0. Stack contents are don't-care.
- en=0: pc, the stack, and the flags hold. pc_next=pc.
- en=1 action is chosen by priority: ret > call > ld > increment. Lower-priority requests asserted in the same cycle are ignored.
  - ret, stack non-empty: pc←top. Pointer decrements and ras_count decrements.
  - ret, stack empty: unf_err←1 and pc←pc+STEP.
  - call: pushes pc+STEP (the pc at the time of the call) and sets pc←ld_addr. ras_count increments.
  - call while full: the oldest entry is overwritten (circular buffer), ras_count stays at RAS_DEPTH, ovf_err←1, and the jump still happens.
  - ld: pc←ld_addr.
  - Otherwise: pc←pc+STEP.
- All pc arithmetic is modulo 2^WIDTH; no wrap flag is produced.
- The stack is a circular buffer of RAS_DEPTH entries with a wrapping top pointer. A pop after an overflow returns the most recent RAS_DEPTH addresses, newest first.
- ovf_err and unf_err clear only on clr.

## Timing
- Every action has single-cycle latency. Inputs sampled at edge N are visible on pc, ras_*, and the flags immediately after edge N.
- pc_next is valid combinationally in the same cycle as its inputs. It has no path to pc other than through the register.
- clr takes effect immediately, without waiting for a clock edge, including mid-cycle. Outputs show reset values while clr=1. The first update happens at the first rising edge with clr=0 and en=1.
- ras_empty, ras_full, and ras_count are decoded from registered state and change only at edges or on clr.

## Test plan
(WIDTH=32, RESET_VEC=0, STEP=1, RAS_DEPTH=4)
1. Count and stall. Stimulus: pulse clr, en=1 for 5 edges, then en=0 for 2 edges. Response: pc=0,1,2,3,4,5, then holds at 5. ras_empty=1 throughout.
2. Wrap-around. Stimulus: ld with ld_addr=0xFFFFFFFE, then 2 increments. Response: pc=0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
3. Call/return. Stimulus: from pc=0x10, call with ld_addr=0x100, 2 increments, then ret. Response:
   - After the call: pc=0x100, ras_count=1.
   - After the increments: pc=0x102.
   - After ret: pc=0x11, ras_count=0, ras_empty=1.
4. Overflow and underflow. Stimulus: from pc=0, 5 back-to-back calls with ld_addr=0x100, 0x200, 0x300, 0x400, 0x500, then 5 rets. Response:
   - After the calls: ovf_err=1, ras_full=1, ras_count=4, pc=0x500.
   - After the first 4 rets: pc=0x401, 0x301, 0x201, 0x101.
   - After the 5th ret: unf_err=1, pc=0x102. Both flags remain 1.
5. Priority. Stimulus: with ras_count=1 holding 0x55, assert ret, call, and ld (ld_addr=0x900) together. Response: pc=0x55, ras_count=0, and there is no push. Then ld+call with ld_addr=0x900 gives pc=0x900 and ras_count=1.
6. Asynchronous reset mid-operation. Stimulus: at pc=0x102 with ovf_err=1, raise clr between edges. Response: pc=0, ras_count=0, and the flags clear before the next edge. With clr held high across an edge while en=1, pc stays 0.
